// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding instruction-memory request, a single
// output register toward decode, and redirects that may arrive in any state.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        imem_rsp_err_i,
  output logic        ifu_valid_o,
  input  logic        idu_ready_i,
  output logic [31:0] insn_o,
  output logic [31:0] pc_o,
  output logic        insn_err_o,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i
);

  typedef enum logic [1:0] {S_REQ, S_RSP, S_OUT, S_FLUSH} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] insn_reg, insn_next;
  logic [31:0] pc_out_reg, pc_out_next;
  logic        valid_reg, valid_next;
  logic        err_reg, err_next;
  logic [31:0] redirect_target;

  assign redirect_target  = redirect_pc_i & ~32'h3;
  // A redirect in S_REQ kills the request in the same cycle it is raised.
  assign imem_req_valid_o = rstn_i && (state_reg == S_REQ) && !redirect_valid_i;
  assign imem_addr_o      = pc_reg;
  assign ifu_valid_o      = valid_reg;
  assign insn_o           = insn_reg;
  assign pc_o             = pc_out_reg;
  assign insn_err_o       = err_reg;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_reg  <= S_REQ;
      pc_reg     <= RESET_PC;
      insn_reg   <= 32'h0;
      pc_out_reg <= 32'h0;
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      insn_reg   <= insn_next;
      pc_out_reg <= pc_out_next;
      valid_reg  <= valid_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    insn_next   = insn_reg;
    pc_out_next = pc_out_reg;
    valid_next  = valid_reg;
    err_next    = err_reg;
    case (state_reg)
      S_REQ: begin
        if (redirect_valid_i) begin
          pc_next = redirect_target;
        end else if (imem_req_ready_i) begin
          state_next = S_RSP;
        end
      end
      S_RSP: begin
        if (redirect_valid_i) begin
          // A response in the redirect cycle is already stale; otherwise wait for it.
          pc_next    = redirect_target;
          state_next = imem_rsp_valid_i ? S_REQ : S_FLUSH;
        end else if (imem_rsp_valid_i) begin
          insn_next   = imem_rsp_data_i;
          pc_out_next = pc_reg;
          err_next    = imem_rsp_err_i;
          valid_next  = 1'b1;
          pc_next     = pc_reg + 32'd4;
          state_next  = S_OUT;
        end
      end
      S_OUT: begin
        if (redirect_valid_i) begin
          pc_next    = redirect_target;
          valid_next = 1'b0;
          state_next = S_REQ;
        end else if (idu_ready_i) begin
          valid_next = 1'b0;
          state_next = S_REQ;
        end
      end
      S_FLUSH: begin
        if (redirect_valid_i) begin
          pc_next = redirect_target;
        end
        if (imem_rsp_valid_i) begin
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
  end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed vector table, randomized run against a transaction
// model, and a wrap/reset sequence on a second instance with RESET_PC at the top.
module tb_ifu;

  localparam logic [31:0] B  = 32'h8000_0000;
  localparam logic [31:0] WB = 32'hFFFF_FFFC;

  logic        clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rstn, req_ready, rsp_valid, rsp_err, idu_ready, redir_v;
  logic [31:0] rsp_data, redir_pc;
  logic        req_valid, ifu_valid, insn_err;
  logic [31:0] req_addr, insn, pc_out;

  logic        w_rstn, w_req_ready, w_rsp_valid, w_idu_ready;
  logic [31:0] w_rsp_data;
  logic        w_req_valid, w_ifu_valid, w_insn_err;
  logic [31:0] w_req_addr, w_insn, w_pc_out;

  int checks = 0;
  int errors = 0;

  ifu u_dut (
    .clk_i(clk_i), .rstn_i(rstn),
    .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_addr_o(req_addr),
    .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data), .imem_rsp_err_i(rsp_err),
    .ifu_valid_o(ifu_valid), .idu_ready_i(idu_ready), .insn_o(insn), .pc_o(pc_out),
    .insn_err_o(insn_err), .redirect_valid_i(redir_v), .redirect_pc_i(redir_pc)
  );

  ifu #(.RESET_PC(WB)) u_wrap (
    .clk_i(clk_i), .rstn_i(w_rstn),
    .imem_req_valid_o(w_req_valid), .imem_req_ready_i(w_req_ready), .imem_addr_o(w_req_addr),
    .imem_rsp_valid_i(w_rsp_valid), .imem_rsp_data_i(w_rsp_data), .imem_rsp_err_i(1'b0),
    .ifu_valid_o(w_ifu_valid), .idu_ready_i(w_idu_ready), .insn_o(w_insn), .pc_o(w_pc_out),
    .insn_err_o(w_insn_err), .redirect_valid_i(1'b0), .redirect_pc_i(32'h0)
  );

  typedef struct {
    logic        rstn, rdy, rv;
    logic [31:0] rd;
    logic        re, ir, rdv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] ea;
    logic        eo;
    logic [31:0] ei, ep;
    logic        ee;
  } vec_t;

  function automatic vec_t V(input logic rs, rdy, rv, input logic [31:0] rd, input logic re, ir, rdv,
                             input logic [31:0] rpc, input logic ev, input logic [31:0] ea,
                             input logic eo, input logic [31:0] ei, ep, input logic ee);
    vec_t v;
    v.rstn = rs; v.rdy = rdy; v.rv = rv; v.rd = rd; v.re = re; v.ir = ir; v.rdv = rdv; v.rpc = rpc;
    v.ev = ev; v.ea = ea; v.eo = eo; v.ei = ei; v.ep = ep; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rs, rdy, rv, input logic [31:0] rd, input logic re, ir, rdv,
                       input logic [31:0] rpc);
    rstn = rs; req_ready = rdy; rsp_valid = rv; rsp_data = rd; rsp_err = re;
    idu_ready = ir; redir_v = rdv; redir_pc = rpc;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  vec_t tbl[$];

  // transaction-level reference state
  logic [31:0] m_pc, m_insn, m_pco;
  logic        m_busy, m_drop, m_valid, m_err, exp_req;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    w_rstn = 0; w_req_ready = 0; w_rsp_valid = 0; w_rsp_data = 0; w_idu_ready = 0;

    tbl.push_back(V(0,0,0,0,0,0,0,0,              0,0,        0,0,0,0));
    tbl.push_back(V(1,1,0,0,0,1,0,0,              1,B,        0,0,0,0));
    tbl.push_back(V(1,1,1,32'h13,0,1,0,0,         0,0,        0,0,0,0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(V(1,0,0,0,0,0,0,0,            0,0,        1,32'h13,B,0));
    tbl.push_back(V(1,0,0,0,0,1,0,0,              0,0,        1,32'h13,B,0));
    tbl.push_back(V(1,1,0,0,0,1,0,0,              1,B+4,      0,0,0,0));
    tbl.push_back(V(1,1,1,32'h00200113,0,1,0,0,   0,0,        0,0,0,0));
    tbl.push_back(V(1,0,0,0,0,1,0,0,              0,0,        1,32'h00200113,B+4,0));
    tbl.push_back(V(1,1,0,0,0,1,0,0,              1,B+8,      0,0,0,0));
    tbl.push_back(V(1,1,1,32'h0,1,1,0,0,          0,0,        0,0,0,0));
    tbl.push_back(V(1,0,0,0,0,1,0,0,              0,0,        1,32'h0,B+8,1));
    tbl.push_back(V(1,1,0,0,0,1,0,0,              1,B+'hC,    0,0,0,0));
    tbl.push_back(V(1,0,1,32'h00300193,0,1,0,0,   0,0,        0,0,0,0));
    tbl.push_back(V(1,0,0,0,0,1,0,0,              0,0,        1,32'h00300193,B+'hC,0));
    tbl.push_back(V(1,1,0,0,0,1,0,0,              1,B+'h10,   0,0,0,0));
    tbl.push_back(V(1,0,0,0,0,1,1,B+'h102,        0,0,        0,0,0,0));
    tbl.push_back(V(1,1,1,32'hDEADBEEF,0,1,0,0,   0,0,        0,0,0,0));
    tbl.push_back(V(1,1,0,0,0,1,0,0,              1,B+'h100,  0,0,0,0));
    tbl.push_back(V(1,0,1,32'h00400213,0,1,0,0,   0,0,        0,0,0,0));
    tbl.push_back(V(1,0,0,0,0,1,1,B+'h203,        0,0,        1,32'h00400213,B+'h100,0));
    tbl.push_back(V(1,1,0,0,0,1,0,0,              1,B+'h200,  0,0,0,0));
    tbl.push_back(V(1,0,1,32'hDEADBEEF,0,1,1,B+'h300, 0,0,    0,0,0,0));
    tbl.push_back(V(1,0,0,0,0,1,0,0,              1,B+'h300,  0,0,0,0));
    tbl.push_back(V(1,1,0,0,0,1,1,B+'h400,        0,0,        0,0,0,0));
    tbl.push_back(V(1,1,0,0,0,1,0,0,              1,B+'h400,  0,0,0,0));
    tbl.push_back(V(1,1,0,0,0,1,0,0,              0,0,        0,0,0,0));
    tbl.push_back(V(1,0,0,0,0,1,1,B+'h500,        0,0,        0,0,0,0));
    tbl.push_back(V(1,0,0,0,0,1,1,B+'h600,        0,0,        0,0,0,0));
    tbl.push_back(V(1,0,1,32'hDEADBEEF,0,1,0,0,   0,0,        0,0,0,0));
    tbl.push_back(V(1,1,0,0,0,1,0,0,              1,B+'h600,  0,0,0,0));
    tbl.push_back(V(1,0,1,32'h11111111,0,1,0,0,   0,0,        0,0,0,0));
    tbl.push_back(V(1,0,0,0,0,1,0,0,              0,0,        1,32'h11111111,B+'h600,0));
    tbl.push_back(V(1,0,0,0,0,0,0,0,              1,B+'h604,  0,0,0,0));

    repeat (2) step();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rstn, tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].re, tbl[i].ir, tbl[i].rdv, tbl[i].rpc);
      #3;
      chk($sformatf("vec%0d_req_valid", i), 32'(req_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("vec%0d_addr", i), req_addr, tbl[i].ea);
      chk($sformatf("vec%0d_ifu_valid", i), 32'(ifu_valid), 32'(tbl[i].eo));
      if (tbl[i].eo || !tbl[i].rstn) begin
        chk($sformatf("vec%0d_insn", i), insn, tbl[i].ei);
        chk($sformatf("vec%0d_pc", i), pc_out, tbl[i].ep);
        chk($sformatf("vec%0d_err", i), 32'(insn_err), 32'(tbl[i].ee));
      end
      step();
    end

    m_pc = B; m_busy = 0; m_drop = 0; m_valid = 0; m_insn = 0; m_pco = 0; m_err = 0;
    for (int n = 0; n < 3000; n++) begin
      drive((n != 0) && ($urandom_range(199) != 0),
            $urandom_range(1) == 1,
            m_busy ? ($urandom_range(1) == 1) : ($urandom_range(19) == 0),
            $urandom, $urandom_range(7) == 0, $urandom_range(1) == 1,
            $urandom_range(11) == 0, $urandom);
      #3;
      exp_req = rstn && !m_busy && !m_valid && !redir_v;
      chk("rnd_req_valid", 32'(req_valid), 32'(exp_req));
      if (exp_req) chk("rnd_addr", req_addr, m_pc);
      chk("rnd_ifu_valid", 32'(ifu_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rnd_insn", insn, m_insn);
        chk("rnd_pc", pc_out, m_pco);
        chk("rnd_err", 32'(insn_err), 32'(m_err));
      end
      if (!rstn) begin
        m_pc = B; m_busy = 0; m_drop = 0; m_valid = 0;
      end else if (m_valid) begin
        if (redir_v || idu_ready) m_valid = 0;
        if (redir_v) m_pc = redir_pc & ~32'h3;
      end else if (m_busy) begin
        if (rsp_valid) begin
          m_busy = 0;
          if (!m_drop && !redir_v) begin
            m_valid = 1; m_insn = rsp_data; m_pco = m_pc; m_err = rsp_err; m_pc = m_pc + 4;
          end
          m_drop = 0;
        end else if (redir_v) begin
          m_drop = 1;
        end
        if (redir_v) m_pc = redir_pc & ~32'h3;
      end else begin
        if (redir_v) m_pc = redir_pc & ~32'h3;
        else if (req_ready) m_busy = 1;
      end
      step();
    end

    #3;
    chk("wrap_rst_req_valid", 32'(w_req_valid), 32'(1'b0));
    chk("wrap_rst_ifu_valid", 32'(w_ifu_valid), 32'(1'b0));
    step();
    w_rstn = 1; w_req_ready = 1; w_idu_ready = 1; #3;
    chk("wrap_req1_valid", 32'(w_req_valid), 32'(1'b1));
    chk("wrap_req1_addr", w_req_addr, WB);
    step();
    w_req_ready = 0; w_rsp_valid = 1; w_rsp_data = 32'h13; #3;
    chk("wrap_rsp_req_valid", 32'(w_req_valid), 32'(1'b0));
    step();
    w_rsp_valid = 0; #3;
    chk("wrap_out_valid", 32'(w_ifu_valid), 32'(1'b1));
    chk("wrap_out_pc", w_pc_out, WB);
    chk("wrap_out_insn", w_insn, 32'h13);
    step();
    w_req_ready = 1; #3;
    chk("wrap_req2_addr", w_req_addr, 32'h0);
    chk("wrap_req2_valid", 32'(w_req_valid), 32'(1'b1));
    step();
    w_rstn = 0; w_req_ready = 0; #3;
    chk("wrap_midrst_req_valid", 32'(w_req_valid), 32'(1'b0));
    step();
    w_rstn = 1; w_rsp_valid = 1; w_rsp_data = 32'hDEADBEEF; #3;
    chk("wrap_after_rst_addr", w_req_addr, WB);
    chk("wrap_after_rst_valid", 32'(w_ifu_valid), 32'(1'b0));
    chk("wrap_after_rst_pc_o", w_pc_out, 32'h0);
    step();
    w_rsp_valid = 0; #3;
    chk("wrap_late_rsp_ignored", 32'(w_ifu_valid), 32'(1'b0));
    chk("wrap_late_req_valid", 32'(w_req_valid), 32'(1'b1));
    chk("wrap_late_addr", w_req_addr, WB);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
